ram_dp_be_clr: RTL and testbench
================================

Name: ram_dp_be_clr

Overview:
- Single-clock, simple dual-port RAM: one write port, one read port.
- Successor to the team's basic dual-port RAM; adds byte-enable writes, a registered read with a valid flag, write-first collision bypass, out-of-range detection, and a hardware clear engine that zeroes the array after reset or on request.
- Storage core for the next-generation synchronous FIFOs and the packet buffers.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per byte-enable lane.
- ADDR_WIDTH, 4, address width in bits.
- RAM_DEPTH, 16, number of words; must satisfy 1 <= RAM_DEPTH <= 2^ADDR_WIDTH.

Ports:
- CLK  input  1  sole clock; all logic on rising edge.
- RST_n  input  1  reset, synchronous, active-low.
- write  input  1  write enable.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- wbe  input  DATA_WIDTH/BYTE_WIDTH  byte enables; bit i covers wdata[i*BYTE_WIDTH +: BYTE_WIDTH].
- read  input  1  read request.
- raddr  input  ADDR_WIDTH  read address.
- rdata  output  DATA_WIDTH  registered read data.
- rvalid  output  1  rdata valid pulse.
- clear  input  1  request a full array clear.
- init_busy  output  1  clear engine active; user accesses ignored.
- addr_err  output  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Interface: one clock (CLK); reset RST_n is synchronous and active-low.
- Reset values (cycle with RST_n=0): rdata=0, rvalid=0, addr_err=0, init_busy=1, clear pointer=0, FSM=INIT.
- Array contents are not reset directly; the INIT sweep zeroes them.

FSM states INIT and RUN:
- INIT: writes all-zero to address ptr each cycle, ptr increments 0..RAM_DEPTH-1.
  - After the cycle writing RAM_DEPTH-1, go to RUN.
  - init_busy deasserts the first RUN cycle.
  - Sweep lasts exactly RAM_DEPTH cycles after RST_n rises.
- RUN: user accesses served. clear=1 in RUN -> INIT next cycle with ptr=0; user ops presented in that same cycle are still served.
- clear=1 during INIT: ignored; the sweep does not restart.
- In INIT: write, read and addr_err are ignored/suppressed; rvalid=0.
- RST_n=0 at any time, including mid-sweep or with a read in flight: immediate return to reset values; the sweep restarts from 0.

Write (RUN, write=1, waddr<RAM_DEPTH):
- Each byte lane with wbe[i]=1 is updated; other lanes are kept.
- wbe all zero: no change.

Read (RUN, read=1):
- Latency 1: rdata and rvalid=1 are presented the cycle after the request.
- rvalid is a one-cycle pulse per request; back-to-back reads give continuous rvalid.
- Without a read, rdata holds its last value and rvalid=0.

Collision (read and write to the same valid address in the same cycle):
- Write-first: rdata = byte-merged result, i.e. new bytes where wbe=1, old bytes elsewhere.

Out of range (address >= RAM_DEPTH, possible only when RAM_DEPTH < 2^ADDR_WIDTH):
- Write: dropped.
- Read: rvalid=1 with rdata=0.
- addr_err pulses the next cycle (aligned with rvalid); one pulse even if both ports are out of range.

Optional Feature:
- Macro RAM_OUT_REG_EN.
- Defined: adds an output register stage.
  - Read latency becomes 2; rvalid and addr_err are delayed identically.
  - The stage is cleared by reset; reads issued in the last RUN cycle before INIT still complete.
- Undefined: latency 1 as above.

Decomposition:
- Package ram_pkg:
  - state typedef {INIT, RUN}.
  - Function/constant NBYTES = DATA_WIDTH/BYTE_WIDTH.
  - Constant RD_LAT (1 or 2, selected by RAM_OUT_REG_EN).
- Sub-module ram_clr_fsm: owns the state, ptr, init_busy and the clear request.
  - Outputs a clear-write strobe and address, muxed ahead of the array write port.
- Top level: array, byte merge, bypass, read pipeline, range check.

Test Plan:
- Reset/init: RST_n low 2 cycles, then high with RAM_DEPTH=16 -> init_busy=1 for exactly 16 cycles; read every address afterwards -> rdata=0, rvalid=1 each cycle after its request.
- Byte enables: write 0xAABBCCDD to addr 3 with wbe=1111, then write 0x11223344 with wbe=0101 -> read addr 3 returns 0xAA22CC44.
- Collision: addr 5 holds 0x0; same cycle write 0xDEADBEEF wbe=1100 and read addr 5 -> next cycle rdata=0xDEAD0000, rvalid=1.
- Range check (RAM_DEPTH=12, ADDR_WIDTH=4): write 0x5 to addr 13 -> addr_err pulse, array unchanged; read addr 13 -> rdata=0, rvalid=1, addr_err=1.
- Clear mid-operation: fill all addresses with 0xFFFFFFFF, pulse clear -> 16 cycles init_busy=1; reads and writes during the sweep produce no rvalid and no change; all addresses read 0 afterwards.
- Reset mid-sweep and RAM_OUT_REG_EN: assert RST_n=0 at sweep cycle 7 -> sweep restarts from ptr=0 and the 16-cycle count restarts.
  - With the macro defined, a read of addr 2 returns data and rvalid two cycles later.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the byte-enable dual-port RAM
//
// Purpose: FSM state type, the byte-lane count helper and the read latency.
// Ports:   none (package).
// Macro:   RAM_OUT_REG_EN selects a read latency of 2 instead of 1.
package ram_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int NBYTES(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

`ifdef RAM_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/ram_clr_fsm.sv
// rtl/ram_clr_fsm.sv - clear engine that zeroes the array after reset or on request
//
// Purpose: INIT/RUN state machine. In INIT it issues one zero-write per cycle,
//          sweeping ptr from 0 to RAM_DEPTH-1, then enters RUN.
// Ports:
//   clk        sole clock
//   rst_n      synchronous active-low reset
//   clear      request a sweep (honoured only in RUN)
//   init_busy  high while sweeping; user accesses are ignored
//   clr_we     zero-write strobe for the array write port
//   clr_addr   address of the zero-write
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        // clear requests during the sweep are ignored; it never restarts
        if (ptr_q == LAST_ADDR) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        if (clear) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign init_busy = (state_q == INIT);
  // no array write while reset is held; the sweep begins once it releases
  assign clr_we    = init_busy & rst_n;
  assign clr_addr  = ptr_q;

endmodule

// File: rtl/ram_dp_be_clr.sv
// rtl/ram_dp_be_clr.sv - simple dual-port RAM with byte enables and a clear engine
//
// Purpose: one write port with per-byte enables, one registered read port with
//          write-first collision bypass, out-of-range detection and a hardware
//          sweep that zeroes the array after reset or on clear.
// Macro:   RAM_OUT_REG_EN adds an output register (read latency 2).
// Ports:
//   CLK        sole clock, rising edge
//   RST_n      synchronous active-low reset
//   write      write enable;  waddr/wdata/wbe  address, data, byte enables
//   read       read request;  raddr  read address
//   rdata      registered read data (holds when no read)
//   rvalid     one-cycle pulse per served read
//   clear      request a full array clear
//   init_busy  clear sweep in progress
//   addr_err   one-cycle pulse when either port addressed beyond RAM_DEPTH
module ram_dp_be_clr
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                             CLK,
  input  logic                             RST_n,
  input  logic                             write,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic                             read,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rvalid,
  input  logic                             clear,
  output logic                             init_busy,
  output logic                             addr_err
);

  localparam int                  NB      = NBYTES(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  ram_clr_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_clr_fsm (
    .clk       (CLK),
    .rst_n     (RST_n),
    .clear     (clear),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  logic                  user_en;
  logic                  wr_in_range, rd_in_range;
  logic                  wr_en, rd_en, collide;
  logic [DATA_WIDTH-1:0] wr_word, rd_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    user_en     = RST_n & ~init_busy;
    wr_in_range = ({1'b0, waddr} < DEPTH_W);
    rd_in_range = ({1'b0, raddr} < DEPTH_W);
    wr_en       = user_en & write & wr_in_range;
    rd_en       = user_en & read;

    // byte merge: new lanes where enabled, stored lanes elsewhere
    wr_word = wr_in_range ? mem_q[waddr] : '0;
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) begin
        wr_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    // write-first: a same-address read sees the merged word
    collide = wr_en & (waddr == raddr);
    if (!rd_in_range) begin
      rd_word = '0;
    end else if (collide) begin
      rd_word = wr_word;
    end else begin
      rd_word = mem_q[raddr];
    end

    // the sweep and user writes are mutually exclusive (user_en excludes INIT)
    mem_we    = clr_we | wr_en;
    mem_waddr = clr_we ? clr_addr : waddr;
    mem_wdata = clr_we ? '0 : wr_word;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // first read stage
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  err1_q, err1_d;

  always_comb begin
    rdata1_d  = rd_en ? rd_word : rdata1_q;
    rvalid1_d = rd_en;
    // one pulse even when both ports are out of range
    err1_d    = user_en & ((write & ~wr_in_range) | (read & ~rd_in_range));
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      rdata1_q  <= '0;
      rvalid1_q <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      rdata1_q  <= rdata1_d;
      rvalid1_q <= rvalid1_d;
      err1_q    <= err1_d;
    end
  end

`ifdef RAM_OUT_REG_EN
  // output stage; not cleared by INIT so reads issued just before a clear finish
  logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
  logic                  rvalid2_q, rvalid2_d;
  logic                  err2_q, err2_d;

  always_comb begin
    rdata2_d  = rdata1_q;
    rvalid2_d = rvalid1_q;
    err2_d    = err1_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      rdata2_q  <= '0;
      rvalid2_q <= 1'b0;
      err2_q    <= 1'b0;
    end else begin
      rdata2_q  <= rdata2_d;
      rvalid2_q <= rvalid2_d;
      err2_q    <= err2_d;
    end
  end

  assign rdata    = rdata2_q;
  assign rvalid   = rvalid2_q;
  assign addr_err = err2_q;
`else
  assign rdata    = rdata1_q;
  assign rvalid   = rvalid1_q;
  assign addr_err = err1_q;
`endif

endmodule

// File: tb/tb_ram_dp_be_clr.sv
// tb/tb_ram_dp_be_clr.sv - scoreboard bench for ram_dp_be_clr
module tb_ram_dp_be_clr;
  import ram_pkg::*;

  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int NB    = DW / BW;

  logic          CLK   = 1'b0;
  logic          RST_n = 1'b0;
  logic          write = 1'b0;
  logic          read  = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wbe   = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          init_busy;
  logic          addr_err;

  ram_dp_be_clr #(
    .DATA_WIDTH (DW),
    .BYTE_WIDTH (BW),
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .write     (write),
    .waddr     (waddr),
    .wdata     (wdata),
    .wbe       (wbe),
    .read      (read),
    .raddr     (raddr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .clear     (clear),
    .init_busy (init_busy),
    .addr_err  (addr_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          e;
    int            due;
  } exp_t;

  exp_t          expq[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  logic [DW-1:0] mdl [DEPTH];
  int            rem   = DEPTH;
  logic          busy_chk = 1'b0;
  logic          busy_exp = 1'b1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compares whatever the DUT presents against the scoreboard
  always @(negedge CLK) begin
    if (busy_chk) check("init_busy", init_busy, busy_exp);
    if (expq.size() > 0 && expq[0].due == cyc) begin
      check("rvalid", rvalid, expq[0].v);
      check("addr_err", addr_err, expq[0].e);
      if (expq[0].v) check("rdata", rdata, expq[0].d);
      void'(expq.pop_front());
    end else if (rvalid || addr_err) begin
      check("rvalid_spurious", rvalid, 1'b0);
      check("addr_err_spurious", addr_err, 1'b0);
    end
  end

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // one clock of stimulus; the model predicts what the coming edge does
  task automatic step(input logic rst, input logic w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [NB-1:0] be,
                      input logic r, input logic [AW-1:0] ra, input logic c);
    exp_t          e;
    exp_t          keep[$];
    logic [DW-1:0] rd;
    logic          err;
    @(posedge CLK);
    #1;
    RST_n = rst; write = w; waddr = wa; wdata = wd; wbe = be;
    read = r; raddr = ra; clear = c;
    if (!rst) begin
      // outputs due this cycle still appear; later ones are lost to the reset
      keep = {};
      foreach (expq[i]) if (expq[i].due <= cyc) keep.push_back(expq[i]);
      expq = keep;
      busy_chk = 1'b0;
      rem = DEPTH;
      zero_model();
    end else begin
      busy_chk = 1'b1;
      busy_exp = (rem > 0);
      if (rem > 0) begin
        rem--;
      end else begin
        err = 1'b0;
        rd  = '0;
        if (w) begin
          if (int'(wa) < DEPTH) begin
            for (int i = 0; i < NB; i++)
              if (be[i]) mdl[wa][i*BW +: BW] = wd[i*BW +: BW];
          end else begin
            err = 1'b1;
          end
        end
        if (r) begin
          if (int'(ra) < DEPTH) rd = mdl[ra];
          else err = 1'b1;
        end
        if (r || err) begin
          e.v = r; e.d = rd; e.e = err; e.due = cyc + RD_LAT;
          expq.push_back(e);
        end
        if (c) begin
          rem = DEPTH;
          zero_model();
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    step(1'b1, 1'b1, a, d, be, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, a, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge CLK);
    check("reset_rdata", rdata, '0);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_addr_err", addr_err, 1'b0);
    check("reset_init_busy", init_busy, 1'b1);
  endtask

  task automatic rand_step(input logic allow_ctl);
    logic          w, r, c, rs;
    logic [AW-1:0] wa, ra;
    rs = allow_ctl ? ($urandom_range(0, 199) != 0) : 1'b1;
    c  = allow_ctl ? ($urandom_range(0, 59) == 0) : 1'b0;
    w  = 1'($urandom_range(0, 1));
    r  = 1'($urandom_range(0, 1)) & ~c;
    wa = AW'($urandom_range(0, 15));
    ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
    step(rs, w, wa, DW'($urandom), NB'($urandom_range(0, 15)), r, ra, c);
  endtask

  initial begin
    // reset and initial sweep, then every address reads zero
    do_reset();
    for (int i = 0; i < DEPTH; i++) idle();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));

    // byte enables
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3);
    wr(4'd7, 32'h12345678, 4'b0000);
    rd(4'd7);

    // collision: write-first merge
    step(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 4'b1100, 1'b1, 4'd5, 1'b0);
    rd(4'd5);

    // out of range on each port, then both at once
    wr(4'd13, 32'h5, 4'b1111);
    rd(4'd13);
    step(1'b1, 1'b1, 4'd14, 32'h9, 4'b1111, 1'b1, 4'd15, 1'b0);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));

    // clear mid-operation with traffic during the sweep
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hFFFFFFFF, 4'b1111);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) rand_step(1'b0);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));

    // reset at sweep cycle 7 restarts the sweep
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) idle();
    wr(4'd2, 32'hCAFEF00D, 4'b1111);
    rd(4'd2);
    rd(4'd2);

    // randomized traffic with occasional clear and reset
    for (int n = 0; n < 1500; n++) rand_step(1'b1);

    for (int i = 0; i < RD_LAT + 3; i++) idle();
    check("queue_drained", DW'(expq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
